inverse_quantizer_pipe: RTL and testbench

INVERSE_QUANTIZER_PIPE -- requirements
Module: inverse_quantizer_pipe

---
 rtl/iq_pkg.sv | 33 +++
 rtl/iq_lane.sv | 83 ++++++++
 rtl/inverse_quantizer_pipe.sv | 169 ++++++++++++++++
 tb/tb_inverse_quantizer_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared constants and helpers for the inverse quantizer pipeline:
// level-scale table, top legal QP and the QP -> (per, rem) decode.
package iq_pkg;

   localparam int QP_MAX = 51;

   localparam logic [6:0] LS_TABLE [6] = '{7'd40, 7'd45, 7'd51, 7'd57, 7'd64, 7'd72};

   typedef struct packed {
      logic [3:0] per;
      logic [2:0] rem;
   } qp_dec_t;

   // per = qp/6, rem = qp%6 from a constant threshold table (no divider)
   function automatic qp_dec_t qp_decode(input int qp);
      int p;
      p = 0;
      for (int k = 1; k <= 8; k++) begin
         if (qp >= 6 * k) p = k;
      end
      qp_decode.per = 4'(p);
      qp_decode.rem = 3'(qp - 6 * p);
   endfunction

   // rem -> LS[rem]; rem values 6/7 never occur for legal QPs
   function automatic logic [6:0] ls_lookup(input logic [2:0] rem);
      ls_lookup = LS_TABLE[0];
      for (int i = 0; i < 6; i++) begin
         if (rem == 3'(i)) ls_lookup = LS_TABLE[i];
      end
   endfunction

endpackage

// File: rtl/iq_lane.sv
// One lane of the inverse quantizer: S2 multiply by LS*2^per, S3 round,
// arithmetic shift and saturate. IQ_SAT_COUNT_EN adds a saturation flag.
module iq_lane #(
   parameter int COEFF_WIDTH = 16,
   parameter int SHIFT       = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic signed [COEFF_WIDTH-1:0] q_i,
   input  logic [6:0]             ls_i,
   input  logic [3:0]             per_i,
   input  logic                   zero_i,
   output logic [COEFF_WIDTH-1:0] coeff_o
`ifdef IQ_SAT_COUNT_EN
   ,output logic                  sat_o
`endif
);

   // Product width: coefficient + 8 bits of signed LS + 8 bits of 2^per
   localparam int PW = COEFF_WIDTH + 16;

   logic signed [PW-1:0]    q_ext, ls_ext, mult, prod_d, prod_q;
   logic signed [PW:0]      rnd, sum, shifted, max_v, min_v;
   logic [COEFF_WIDTH-1:0]  res, coeff_d, coeff_q;
   logic                    res_sat, sat_d, sat_q;

   // S2: signed scale by LS[rem], then by 2^per; holds when stalled
   always_comb begin
      q_ext  = PW'(q_i);
      ls_ext = $signed({{(PW-7){1'b0}}, ls_i});
      mult   = q_ext * ls_ext;
      prod_d = en ? (mult <<< per_i) : prod_q;
   end

   // S3: add half, floor-shift, clamp to the coefficient range
   always_comb begin
      rnd            = '0;
      rnd[SHIFT-1]   = 1'b1;
      sum            = {prod_q[PW-1], prod_q};
      sum            = sum + rnd;
      shifted        = sum >>> SHIFT;
      max_v          = '0;
      max_v[COEFF_WIDTH-2:0] = '1;
      min_v          = '1;
      min_v[COEFF_WIDTH-2:0] = '0;
      res            = shifted[COEFF_WIDTH-1:0];
      res_sat        = 1'b0;
      if (zero_i) begin
         res = '0;
      end else if (shifted > max_v) begin
         res     = max_v[COEFF_WIDTH-1:0];
         res_sat = 1'b1;
      end else if (shifted < min_v) begin
         res     = min_v[COEFF_WIDTH-1:0];
         res_sat = 1'b1;
      end
      coeff_d = en ? res : coeff_q;
      sat_d   = en ? res_sat : sat_q;
   end

   // Product register carries no reset; it is qualified by the valid pipe
   always_ff @(posedge clk) begin
      prod_q <= prod_d;
   end

   // Output register resets so out_coeff reads zero during reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         coeff_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         coeff_q <= coeff_d;
         sat_q   <= sat_d;
      end
   end

   assign coeff_o = coeff_q;
`ifdef IQ_SAT_COUNT_EN
   assign sat_o = sat_q;
`endif

endmodule

// File: rtl/inverse_quantizer_pipe.sv
// Three-stage inverse quantizer: S1 QP decode and block framing,
// S2 multiply, S3 round/shift/saturate (per lane in iq_lane).
// Optional macro IQ_SAT_COUNT_EN adds the sat_count port and counter.
//
// Handshake: a beat moves on a rising edge when valid && ready. The whole
// pipe advances when (!s3_valid || out_ready); in_ready is that enable, so
// a stalled output freezes every stage and nothing is dropped or repeated.
module inverse_quantizer_pipe
   import iq_pkg::*;
#(
   parameter int COEFF_WIDTH = 16,
   parameter int QP_WIDTH    = 6,
   parameter int LANES       = 4,
   parameter int BLOCK_BEATS = 4,
   parameter int SHIFT       = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_sop,
   input  logic [QP_WIDTH-1:0]          in_qp,
   input  logic [LANES*COEFF_WIDTH-1:0] in_coeff,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_sop,
   output logic                         out_eop,
   output logic [LANES*COEFF_WIDTH-1:0] out_coeff
`ifdef IQ_SAT_COUNT_EN
   ,output logic [15:0]                 sat_count
`endif
);

   localparam int CNT_W = $clog2(BLOCK_BEATS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BEATS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BLOCK_BEATS);

   logic                         en, accept;
   logic [QP_WIDTH-1:0]          qp_eff, qp_q, qp_d;
   logic [CNT_W-1:0]             beat_idx, cnt_q, cnt_d;
   qp_dec_t                      dec;
   logic                         s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic                         s3_valid_q, s3_valid_d;
   logic                         s1_sop_q, s1_sop_d, s1_eop_q, s1_eop_d, s1_zero_q, s1_zero_d;
   logic                         s2_sop_q, s2_sop_d, s2_eop_q, s2_eop_d, s2_zero_q, s2_zero_d;
   logic                         s3_sop_q, s3_sop_d, s3_eop_q, s3_eop_d;
   logic [LANES*COEFF_WIDTH-1:0] s1_coeff_q, s1_coeff_d;
   logic [3:0]                   s1_per_q, s1_per_d;
   logic [6:0]                   s1_ls_q, s1_ls_d;

   assign en       = !s3_valid_q || out_ready;
   assign in_ready = en;
   assign accept   = in_valid && en;

   // S1: effective QP, per/rem decode, beat index and sop/eop framing
   always_comb begin
      qp_eff   = in_sop ? in_qp : qp_q;
      beat_idx = in_sop ? '0 : cnt_q;
      dec      = qp_decode((int'(qp_eff) > QP_MAX) ? 0 : int'(qp_eff));
      qp_d     = (accept && in_sop) ? in_qp : qp_q;
      cnt_d    = cnt_q;
      if (accept) begin
         if (in_sop)                cnt_d = CNT_W'(1);
         else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end
      s1_coeff_d = en ? in_coeff : s1_coeff_q;
      s1_per_d   = en ? dec.per : s1_per_q;
      s1_ls_d    = en ? ls_lookup(dec.rem) : s1_ls_q;
      s1_zero_d  = en ? (int'(qp_eff) > QP_MAX) : s1_zero_q;
      s1_sop_d   = en ? in_sop : s1_sop_q;
      s1_eop_d   = en ? (beat_idx == CNT_LAST) : s1_eop_q;
   end

   // Valid bits and framing flags shift forward together on enable
   always_comb begin
      s1_valid_d = en ? in_valid   : s1_valid_q;
      s2_valid_d = en ? s1_valid_q : s2_valid_q;
      s3_valid_d = en ? s2_valid_q : s3_valid_q;
      s2_sop_d   = en ? s1_sop_q   : s2_sop_q;
      s2_eop_d   = en ? s1_eop_q   : s2_eop_q;
      s2_zero_d  = en ? s1_zero_q  : s2_zero_q;
      s3_sop_d   = en ? s2_sop_q   : s3_sop_q;
      s3_eop_d   = en ? s2_eop_q   : s3_eop_q;
   end

   // Control state: cleared asynchronously so in-flight beats are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qp_q       <= '0;
         cnt_q      <= '0;
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         s3_sop_q   <= 1'b0;
         s3_eop_q   <= 1'b0;
      end else begin
         qp_q       <= qp_d;
         cnt_q      <= cnt_d;
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s3_valid_q <= s3_valid_d;
         s3_sop_q   <= s3_sop_d;
         s3_eop_q   <= s3_eop_d;
      end
   end

   // Data-side stage registers, qualified by the valid bits
   always_ff @(posedge clk) begin
      s1_coeff_q <= s1_coeff_d;
      s1_per_q   <= s1_per_d;
      s1_ls_q    <= s1_ls_d;
      s1_zero_q  <= s1_zero_d;
      s1_sop_q   <= s1_sop_d;
      s1_eop_q   <= s1_eop_d;
      s2_sop_q   <= s2_sop_d;
      s2_eop_q   <= s2_eop_d;
      s2_zero_q  <= s2_zero_d;
   end

`ifdef IQ_SAT_COUNT_EN
   logic [LANES-1:0] lane_sat;
`endif

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      iq_lane #(
         .COEFF_WIDTH (COEFF_WIDTH),
         .SHIFT       (SHIFT)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en),
         .q_i     (s1_coeff_q[l*COEFF_WIDTH +: COEFF_WIDTH]),
         .ls_i    (s1_ls_q),
         .per_i   (s1_per_q),
         .zero_i  (s2_zero_q),
         .coeff_o (out_coeff[l*COEFF_WIDTH +: COEFF_WIDTH])
`ifdef IQ_SAT_COUNT_EN
         ,.sat_o  (lane_sat[l])
`endif
      );
   end

   assign out_valid = s3_valid_q;
   assign out_sop   = s3_sop_q;
   assign out_eop   = s3_eop_q;

`ifdef IQ_SAT_COUNT_EN
   logic [15:0] sat_cnt_q, sat_cnt_d;

   // Add saturated lanes of each consumed beat, sticking at all-ones
   always_comb begin
      int tot;
      tot = int'(sat_cnt_q);
      if (s3_valid_q && out_ready) begin
         for (int l = 0; l < LANES; l++) tot = tot + int'(lane_sat[l]);
      end
      sat_cnt_d = (tot > 65535) ? 16'hFFFF : 16'(tot);
   end

   // Saturation counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sat_cnt_q <= '0;
      else        sat_cnt_q <= sat_cnt_d;
   end

   assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_inverse_quantizer_pipe.sv
// Directed bench for inverse_quantizer_pipe with a scoreboard queue.
// Honors IQ_SAT_COUNT_EN for the optional sat_count port.
module tb_inverse_quantizer_pipe;

   localparam int W = 66;   // {sop, eop, 4 x 16-bit lanes}

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_sop = 1'b0;
   logic [5:0]  in_qp = '0;
   logic [63:0] in_coeff = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_sop;
   logic        out_eop;
   logic [63:0] out_coeff;
`ifdef IQ_SAT_COUNT_EN
   logic [15:0] sat_count;
`endif

   logic [W-1:0] exp_q[$];
   int           checks = 0;
   int           failures = 0;
   bit           rand_ready = 1'b0;
   logic         ready_force = 1'b1;

   inverse_quantizer_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sop    (in_sop),
      .in_qp     (in_qp),
      .in_coeff  (in_coeff),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sop   (out_sop),
      .out_eop   (out_eop),
      .out_coeff (out_coeff)
`ifdef IQ_SAT_COUNT_EN
      ,.sat_count (sat_count)
`endif
   );

   // Clock
   always #5 clk = ~clk;

   // Downstream ready: forced level or random backpressure
   always @(posedge clk) begin
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] cf(input int c0, input int c1, input int c2, input int c3);
      cf = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
   endfunction

   function automatic logic [W-1:0] ex(input logic sop, input logic eop,
                                        input int c0, input int c1, input int c2, input int c3);
      ex = {sop, eop, cf(c0, c1, c2, c3)};
   endfunction

   // Monitor: pop and compare every consumed output beat
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%h expected=none", {out_sop, out_eop, out_coeff});
         end else begin
            check("out_beat", {out_sop, out_eop, out_coeff}, exp_q.pop_front());
         end
      end
   end

   // Driver: present one beat, wait (bounded) for acceptance
   task automatic send_beat(input logic sop, input logic [5:0] qp, input logic [63:0] coeff,
                            input logic [W-1:0] exp, input bit push);
      int n;
      in_valid = 1'b1;
      in_sop   = sop;
      in_qp    = qp;
      in_coeff = coeff;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout actual=in_ready_low expected=accept");
      end
      @(posedge clk);
      if (push) exp_q.push_back(exp);
      #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_left", W'(exp_q.size()), '0);
   endtask

   initial begin
      int n;
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_out_sop", W'(out_sop), W'(0));
      check("rst_out_eop", W'(out_eop), W'(0));
      check("rst_out_coeff", W'(out_coeff), W'(0));
      check("rst_in_ready", W'(in_ready), W'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // QP=0: 10->6, -10->-6, 1->1; then latency
      send_beat(1'b1, 6'd0, cf(10, -10, 0, 1), ex(1'b1, 1'b0, 6, -6, 0, 1), 1'b1);
      n = 1;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", W'(n), W'(3));

      // QP=28 (per 4, LS 64)
      send_beat(1'b1, 6'd28, cf(10, -10, 100, -1), ex(1'b1, 1'b0, 160, -160, 1600, -16), 1'b1);
      // QP=51 saturation both ways (two saturated lanes)
      send_beat(1'b1, 6'd51, cf(32767, -32768, 0, 1), ex(1'b1, 1'b0, 32767, -32768, 0, 228), 1'b1);
      // QP=52 forces zero, not a saturation
      send_beat(1'b1, 6'd52, cf(100, -100, 32767, 5), ex(1'b1, 1'b0, 0, 0, 0, 0), 1'b1);
      drain();
`ifdef IQ_SAT_COUNT_EN
      check("sat_count_2", W'(sat_count), W'(2));
`endif

      // QP=12 four-beat block under random backpressure; later QPs ignored
      rand_ready = 1'b1;
      send_beat(1'b1, 6'd12, cf(1, 2, 3, -1), ex(1'b1, 1'b0, 3, 5, 8, -2), 1'b1);
      idle($urandom_range(0, 2));
      send_beat(1'b0, 6'd40, cf(4, -4, 100, 0), ex(1'b0, 1'b0, 10, -10, 250, 0), 1'b1);
      idle($urandom_range(0, 2));
      send_beat(1'b0, 6'd0, cf(10, -10, 200, -200), ex(1'b0, 1'b0, 25, -25, 500, -500), 1'b1);
      idle($urandom_range(0, 2));
      send_beat(1'b0, 6'd63, cf(204, 205, -205, 7), ex(1'b0, 1'b1, 510, 513, -512, 18), 1'b1);
      // Truncated block: sop QP=6, one more beat, then a new sop QP=0
      send_beat(1'b1, 6'd6, cf(8, 0, 0, 0), ex(1'b1, 1'b0, 10, 0, 0, 0), 1'b1);
      send_beat(1'b0, 6'd0, cf(8, 0, 0, 0), ex(1'b0, 1'b0, 10, 0, 0, 0), 1'b1);
      send_beat(1'b1, 6'd0, cf(64, 0, 0, 0), ex(1'b1, 1'b0, 40, 0, 0, 0), 1'b1);
      drain();
      rand_ready  = 1'b0;
      ready_force = 1'b1;

      // Reset with two beats in flight, output stalled
      ready_force = 1'b0;
      idle(2);
      send_beat(1'b1, 6'd0, cf(10, 10, 10, 10), '0, 1'b0);
      send_beat(1'b0, 6'd0, cf(20, 20, 20, 20), '0, 1'b0);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("stall_out_valid", W'(out_valid), W'(1));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst2_out_valid", W'(out_valid), W'(0));
      check("rst2_out_sop", W'(out_sop), W'(0));
      check("rst2_out_coeff", W'(out_coeff), W'(0));
      check("rst2_in_ready", W'(in_ready), W'(1));
`ifdef IQ_SAT_COUNT_EN
      check("rst2_sat_count", W'(sat_count), W'(0));
`endif
      ready_force = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Beats before any sop: QP=0, count from 0, eop at index 3 only
      send_beat(1'b0, 6'd30, cf(10, -10, 0, 1), ex(1'b0, 1'b0, 6, -6, 0, 1), 1'b1);
      send_beat(1'b0, 6'd30, cf(10, -10, 0, 1), ex(1'b0, 1'b0, 6, -6, 0, 1), 1'b1);
      send_beat(1'b0, 6'd30, cf(10, -10, 0, 1), ex(1'b0, 1'b0, 6, -6, 0, 1), 1'b1);
      send_beat(1'b0, 6'd30, cf(10, -10, 0, 1), ex(1'b0, 1'b1, 6, -6, 0, 1), 1'b1);
      send_beat(1'b0, 6'd30, cf(10, -10, 0, 1), ex(1'b0, 1'b0, 6, -6, 0, 1), 1'b1);
      drain();
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
